// File: rtl/flopr_reg.sv
// Resettable D register: captures d on every rising clk, async active-high reset to RESET_VAL.
// Generic pipeline/state register (PC, stage registers); port order is positional-stable.
module flopr_reg #(
    parameter int unsigned           WIDTH     = 32,
    parameter logic [WIDTH-1:0]      RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset dominates any coincident clock edge; no enable, capture every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: tb/tb_flopr_reg.sv
// Directed self-checking bench for flopr_reg: default 32-bit instance plus an
// 8-bit instance with a non-zero reset value.
module tb_flopr_reg;

    logic        clk;
    logic        reset;
    logic [31:0] d;
    logic [31:0] q;
    logic        reset8;
    logic [7:0]  d8;
    logic [7:0]  q8;

    int n_tests;
    int n_fail;

    logic [31:0] vals [10];
    logic [31:0] prev;

    flopr_reg dut32 (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .q     (q)
    );

    flopr_reg #(
        .WIDTH     (8),
        .RESET_VAL (8'h3C)
    ) dut8 (
        .clk   (clk),
        .reset (reset8),
        .d     (d8),
        .q     (q8)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: q=%h expected %h", tag, got, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: q8=%h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        d       = 32'h0000_0000;
        reset8  = 1'b1;
        d8      = 8'h00;

        // Reset from time 0, held through the first clock edge.
        #1;
        check32("reset_t0", q, 32'h0000_0000);
        check8("reset8_t0", q8, 8'h3C);
        @(posedge clk); #1;
        check32("reset_through_edge", q, 32'h0000_0000);
        check8("reset8_through_edge", q8, 8'h3C);

        // Release at 20 ns; first capture at the 30 ns edge.
        @(negedge clk);
        reset  = 1'b0;
        d      = 32'h1215_3524;
        reset8 = 1'b0;
        d8     = 8'hC3;
        #1;
        check32("release_no_capture", q, 32'h0000_0000);
        check8("release8_no_capture", q8, 8'h3C);
        @(posedge clk); #1;
        check32("first_capture", q, 32'h1215_3524);
        check8("capture8", q8, 8'hC3);
        @(negedge clk);
        d  = 32'h0BAD_F00D;
        d8 = 8'h5A;
        #8;
        check32("hold_until_50", q, 32'h1215_3524);
        check8("hold8", q8, 8'hC3);

        // Streaming: one new value per cycle, 1-cycle latency.
        for (int i = 0; i < 10; i++) vals[i] = $urandom;
        prev = 32'h0BAD_F00D;
        @(posedge clk); #1;
        check32("stream_pre", q, prev);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            d = vals[i];
            #1;
            check32($sformatf("stream_hold_%0d", i), q, prev);
            @(posedge clk); #1;
            check32($sformatf("stream_cap_%0d", i), q, vals[i]);
            prev = vals[i];
        end

        // Asynchronous reset between edges.
        @(negedge clk);
        d  = 32'hDEAD_BEEF;
        d8 = 8'h77;
        @(posedge clk); #1;
        check32("pre_async", q, 32'hDEAD_BEEF);
        check8("pre_async8", q8, 8'h77);
        #4;
        reset  = 1'b1;
        reset8 = 1'b1;
        #1;
        check32("async_reset", q, 32'h0000_0000);
        check8("async_reset8", q8, 8'h3C);
        d  = 32'hFFFF_FFFF;
        d8 = 8'hFF;
        @(posedge clk); #1;
        check32("reset_wins_edge", q, 32'h0000_0000);
        check8("reset8_wins_edge", q8, 8'h3C);
        #3;
        check32("reset_held_20ns", q, 32'h0000_0000);
        #1;
        reset  = 1'b0;
        reset8 = 1'b0;
        d      = 32'hA5A5_A5A5;
        d8     = 8'hC3;
        #1;
        check32("release_mid_cycle", q, 32'h0000_0000);
        @(posedge clk); #1;
        check32("capture_after_release", q, 32'hA5A5_A5A5);
        check8("capture8_after_release", q8, 8'hC3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
